// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the 7-segment scan-timing generator
package seg_pkg;

   localparam logic [1:0] ST_PARK = 2'd0;
   localparam logic [1:0] ST_SHOW = 2'd1;
   localparam logic [1:0] ST_DEAD = 2'd2;

   localparam logic [1:0] DIG0 = 2'd0;
   localparam logic [1:0] DIG1 = 2'd1;
   localparam logic [1:0] DIG2 = 2'd2;
   localparam logic [1:0] DIG3 = 2'd3;

   localparam logic [15:0] SEG_DEFAULT_DIV = 16'd50000;

endpackage

// File: rtl/seg_blink_timer.sv
// rtl/seg_blink_timer.sv - counts display frames and toggles a blink phase every BLINK_FRAMES frames
module seg_blink_timer #(
   parameter int BLINK_FRAMES = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_tick,
   output logic blink_phase
);

   localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic               blink_phase_q, blink_phase_d;

   always_comb begin
      frame_cnt_d   = frame_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_tick) begin
         if (frame_cnt_q == FRAME_LAST) begin
            frame_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + FRAME_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
      end else begin
         frame_cnt_q   <= frame_cnt_d;
         blink_phase_q <= blink_phase_d;
      end
   end

   assign blink_phase = blink_phase_q;

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - digit scan timing with dwell divider, dead-time blanking and blink phase
// Optional SEG_SCAN_DIM_EN adds a 2-bit dim input that shortens the lit part of each dwell.
module seg_scan_ctrl
   import seg_pkg::*;
#(
   parameter int                    PRESCALE_W   = 16,
   parameter logic [PRESCALE_W-1:0] DEFAULT_DIV  = PRESCALE_W'(SEG_DEFAULT_DIV),
   parameter int                    DEAD_CYCLES  = 8,
   parameter int                    BLINK_FRAMES = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scan_en,
   input  logic                  div_load,
   input  logic [PRESCALE_W-1:0] div_val,
`ifdef SEG_SCAN_DIM_EN
   input  logic [1:0]            dim,
`endif
   output logic [1:0]            Scanning,
   output logic                  blank,
   output logic                  digit_tick,
   output logic                  frame_tick,
   output logic                  blink_phase
);

   localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
   localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);

   logic [1:0]            state_q, state_d;
   logic [1:0]            scanning_q, scanning_d;
   logic                  blank_q, blank_d;
   logic                  digit_tick_q, digit_tick_d;
   logic                  frame_tick_q, frame_tick_d;
   logic [PRESCALE_W-1:0] div_reg_q, div_reg_d;
   logic [PRESCALE_W-1:0] pending_div_q, pending_div_d;
   logic [PRESCALE_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic [DEAD_W-1:0]     dead_cnt_q, dead_cnt_d;
   logic [PRESCALE_W-1:0] eff_div;
   logic                  advance;
`ifdef SEG_SCAN_DIM_EN
   logic [1:0]            dim_q, dim_d;
   logic [PRESCALE_W-1:0] eff_div_nxt;
`endif

   always_comb begin
      state_d       = state_q;
      scanning_d    = scanning_q;
      div_reg_d     = div_reg_q;
      dwell_cnt_d   = dwell_cnt_q;
      dead_cnt_d    = dead_cnt_q;
      pending_div_d = div_load ? div_val : pending_div_q;
      digit_tick_d  = 1'b0;
      frame_tick_d  = 1'b0;
      advance       = 1'b0;
      eff_div       = (div_reg_q == '0) ? PRESCALE_W'(1) : div_reg_q;
`ifdef SEG_SCAN_DIM_EN
      dim_d         = dim_q;
`endif

      case (state_q)
         ST_PARK: begin
            if (scan_en) begin
               state_d     = ST_SHOW;
               dwell_cnt_d = '0;
               div_reg_d   = pending_div_d;
`ifdef SEG_SCAN_DIM_EN
               dim_d       = dim;
`endif
            end
         end
         ST_SHOW: begin
            if (!scan_en) begin
               state_d     = ST_PARK;
               dwell_cnt_d = '0;
               dead_cnt_d  = '0;
            end else if (dwell_cnt_q == eff_div - PRESCALE_W'(1)) begin
               if (DEAD_CYCLES > 0) begin
                  state_d    = ST_DEAD;
                  dead_cnt_d = '0;
               end else begin
                  advance = 1'b1;
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q + PRESCALE_W'(1);
            end
         end
         ST_DEAD: begin
            if (!scan_en) begin
               state_d     = ST_PARK;
               dwell_cnt_d = '0;
               dead_cnt_d  = '0;
            end else if (dead_cnt_q == DEAD_LAST) begin
               advance = 1'b1;
            end else begin
               dead_cnt_d = dead_cnt_q + DEAD_W'(1);
            end
         end
         default: state_d = ST_PARK;
      endcase

      // A load arriving on the boundary cycle already governs the digit that starts here.
      if (advance) begin
         state_d      = ST_SHOW;
         scanning_d   = scanning_q + 2'd1;
         digit_tick_d = 1'b1;
         frame_tick_d = (scanning_q == DIG3);
         div_reg_d    = pending_div_d;
         dwell_cnt_d  = '0;
`ifdef SEG_SCAN_DIM_EN
         dim_d        = dim;
`endif
      end

`ifdef SEG_SCAN_DIM_EN
      eff_div_nxt = (div_reg_d == '0) ? PRESCALE_W'(1) : div_reg_d;
      blank_d     = (state_d != ST_SHOW) || (dwell_cnt_d >= (eff_div_nxt >> dim_d));
`else
      blank_d     = (state_d != ST_SHOW);
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_PARK;
         scanning_q    <= DIG0;
         blank_q       <= 1'b1;
         digit_tick_q  <= 1'b0;
         frame_tick_q  <= 1'b0;
         div_reg_q     <= DEFAULT_DIV;
         pending_div_q <= DEFAULT_DIV;
         dwell_cnt_q   <= '0;
         dead_cnt_q    <= '0;
`ifdef SEG_SCAN_DIM_EN
         dim_q         <= 2'd0;
`endif
      end else begin
         state_q       <= state_d;
         scanning_q    <= scanning_d;
         blank_q       <= blank_d;
         digit_tick_q  <= digit_tick_d;
         frame_tick_q  <= frame_tick_d;
         div_reg_q     <= div_reg_d;
         pending_div_q <= pending_div_d;
         dwell_cnt_q   <= dwell_cnt_d;
         dead_cnt_q    <= dead_cnt_d;
`ifdef SEG_SCAN_DIM_EN
         dim_q         <= dim_d;
`endif
      end
   end

   // Fed the wrap event directly so blink_phase flips in step with frame_tick.
   seg_blink_timer #(
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_blink (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick_d),
      .blink_phase(blink_phase)
   );

   assign Scanning   = scanning_q;
   assign blank      = blank_q;
   assign digit_tick = digit_tick_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb/tb_seg_scan_ctrl.sv - randomized self-checking bench for seg_scan_ctrl against a period-position model
module tb_seg_scan_ctrl;

   localparam int DEF_DIV = 4;
   localparam int DEAD    = 2;
   localparam int BLINK   = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_en = 1'b0;
   logic        div_load = 1'b0;
   logic [15:0] div_val = 16'd0;
`ifdef SEG_SCAN_DIM_EN
   logic [1:0]  dim = 2'd0;
`endif
   logic [1:0]  scanning;
   logic        blank, digit_tick, frame_tick, blink_phase;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;

   // Model: a digit occupies a period of div + DEAD cycles; blank once past the lit part.
   bit m_run = 0;
   int m_pos = 0, m_div = DEF_DIV, m_pend = DEF_DIV, m_digit = 0, m_frames = 0;
   bit m_tick = 0, m_ftick = 0;

   bit chk_period = 0;
   int last_dt = -1, last_ft = -1;

   always #5 clk = ~clk;

   seg_scan_ctrl #(
      .PRESCALE_W  (16),
      .DEFAULT_DIV (16'(DEF_DIV)),
      .DEAD_CYCLES (DEAD),
      .BLINK_FRAMES(BLINK)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .scan_en    (scan_en),
      .div_load   (div_load),
      .div_val    (div_val),
`ifdef SEG_SCAN_DIM_EN
      .dim        (dim),
`endif
      .Scanning   (scanning),
      .blank      (blank),
      .digit_tick (digit_tick),
      .frame_tick (frame_tick),
      .blink_phase(blink_phase)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int eff(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic model_step();
      int pend_next;
      m_tick  = 0;
      m_ftick = 0;
      pend_next = div_load ? int'(div_val) : m_pend;
      if (!rst_n) begin
         m_run = 0; m_pos = 0; m_digit = 0; m_frames = 0;
         m_div = DEF_DIV; pend_next = DEF_DIV;
      end else if (!m_run) begin
         if (scan_en) begin
            m_run = 1; m_pos = 0; m_div = eff(pend_next);
         end
      end else if (!scan_en) begin
         m_run = 0; m_pos = 0;
      end else if (m_pos == m_div + DEAD - 1) begin
         m_tick = 1;
         if (m_digit == 3) begin
            m_ftick = 1;
            m_frames++;
         end
         m_digit = (m_digit + 1) % 4;
         m_div   = eff(pend_next);
         m_pos   = 0;
      end else begin
         m_pos++;
      end
      m_pend = pend_next;
   endtask

   task automatic compare_outputs();
      check("scanning", 32'(scanning), 32'(m_digit));
      check("blank", 32'(blank), 32'(!m_run || m_pos >= m_div));
      check("digit_tick", 32'(digit_tick), 32'(m_tick));
      check("frame_tick", 32'(frame_tick), 32'(m_ftick));
      check("blink_phase", 32'(blink_phase), 32'((m_frames / BLINK) % 2));
   endtask

   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
      compare_outputs();
      if (chk_period) begin
         if (digit_tick) begin
            if (last_dt >= 0) check("digit_period", 32'(cyc - last_dt), 32'(DEF_DIV + DEAD));
            last_dt = cyc;
         end
         if (frame_tick) begin
            if (last_ft >= 0) check("frame_period", 32'(cyc - last_ft), 32'(4 * (DEF_DIV + DEAD)));
            last_ft = cyc;
         end
      end
      div_load = 1'b0;
   endtask

   task automatic wait_for(input logic [1:0] dig, input logic want_blank, input string tag);
      bit found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (scanning == dig && blank == want_blank) found = 1;
         else step();
      end
      check(tag, 32'(found), 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      repeat (3) step();
      check("rst_scanning", 32'(scanning), 32'd0);
      check("rst_blank", 32'(blank), 32'd1);
      check("rst_blink", 32'(blink_phase), 32'd0);

      // Default divisor, steady scanning over several frames
      rst_n = 1'b1;
      scan_en = 1'b1;
      chk_period = 1;
      repeat (130) step();
      chk_period = 0;

      // Divisor change mid-dwell of digit 1 must not cut that dwell short
      wait_for(2'd1, 1'b0, "wait_dig1_show");
      step();
      div_val = 16'd10;
      div_load = 1'b1;
      repeat (70) step();

      // Divisor zero acts as one
      div_val = 16'd0;
      div_load = 1'b1;
      repeat (30) step();

      // Park during dead time of digit 2
      div_val = 16'd4;
      div_load = 1'b1;
      wait_for(2'd2, 1'b1, "wait_dig2_dead");
      scan_en = 1'b0;
      step();
      check("park_blank", 32'(blank), 32'd1);
      check("park_scanning", 32'(scanning), 32'd2);
      check("park_tick", 32'(digit_tick), 32'd0);
      repeat (4) step();
      scan_en = 1'b1;
      repeat (20) step();

      // Reset while showing digit 3
      wait_for(2'd3, 1'b0, "wait_dig3_show");
      rst_n = 1'b0;
      step();
      check("rst3_scanning", 32'(scanning), 32'd0);
      check("rst3_blank", 32'(blank), 32'd1);
      check("rst3_blink", 32'(blink_phase), 32'd0);
      rst_n = 1'b1;
      step();
      check("rst3_park_blank", 32'(blank), 32'd0);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) scan_en = ~scan_en;
         if ($urandom_range(0, 24) == 0) begin
            div_load = 1'b1;
            div_val  = 16'($urandom_range(0, 9));
         end
         rst_n = ($urandom_range(0, 799) != 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
